arbiter_rr_n: RTL
=================

// Module: arbiter_rr_n
// PURPOSE
//  N-way round-robin arbiter with a bounded grant tenure. Registered one-hot grant plus encoded owner index.
//  Replaces fixed 3-way arbiters on shared FPGA resources (SPI master, buffer RAM port).
//  Adds a hold-while-requesting policy with a per-grant cycle limit, so one requester cannot starve the others.
// PARAMETERS
//  N         3   number of requesters, N >= 2
//  MAX_HOLD  4   max consecutive grant cycles per tenure; 0 = unlimited (hold while req stays high)
//  IDW       derived localparam = max(1, $clog2(N)); width of gnt_id
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst        in   1    reset, asynchronous assert, active-low (0 = reset)
//  req        in   N    request vector; req[i] high = requester i wants the resource
//  lock       in   1    present only with ARB_RR_LOCK_EN; owner keeps grant beyond MAX_HOLD
//  gnt        out  N    registered grant, one-hot or all-zero
//  gnt_valid  out  1    registered; high when gnt != 0
//  gnt_id     out  IDW  registered binary index of owner; 0 when gnt_valid is low
// BEHAVIOUR
//  Reset (rst=0, asynchronous): gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, last_owner=N-1, so req[0] has top priority after reset.
//  Registers: gnt/gnt_id (owner), hold_cnt (counts cycles of the current tenure), last_owner (index of the most recent grant).
//  Latency: from an idle arbiter, req sampled at edge k gives gnt at edge k (visible the following cycle). No combinational req->gnt path.
//  Each edge, evaluated in priority order:
//   KEEP: valid owner o, req[o]=1, and (MAX_HOLD=0 or hold_cnt < MAX_HOLD-1) -> gnt unchanged, hold_cnt++.
//   ROTATE: otherwise, scan i = last_owner+1 .. last_owner+N (mod N). The first i with req[i]=1 becomes owner.
//     Set gnt=1<<i, gnt_id=i, last_owner=i, hold_cnt=0.
//   IDLE: no req high -> gnt=0, gnt_valid=0, gnt_id=0. last_owner retained.
//  Release is bubble-free: when the owner drops req, another pending requester is granted on the same edge.
//  Tenure expiry with only the owner requesting -> scan wraps to the owner; it is re-granted with hold_cnt=0. No idle cycle.
//  Wrap-around: the scan is modulo N. The index after N-1 is 0. Scan arithmetic sized IDW+1 to avoid overflow when N is not a power of 2.
//  Simultaneous requests: all req high from idle after reset -> tenures go to 0,1,...,N-1,0, ...
//  Invariants: gnt is never multi-hot. gnt_valid == |gnt. gnt_id == encode(gnt).
//  hold_cnt saturates at MAX_HOLD-1. When MAX_HOLD=0, hold_cnt is unused and may be optimised out.
//  Reset mid-tenure: all outputs clear asynchronously. After release, arbitration restarts from requester 0.
// CONFIGURATION
//  ARB_RR_LOCK_EN defined:
//   - lock port exists.
//   - If lock=1 and req[owner]=1 -> KEEP regardless of hold_cnt; hold_cnt holds at its saturated value.
//   - lock is ignored when there is no owner, and cannot create a grant.
//   - When lock falls with hold_cnt at limit -> ROTATE on the next edge.
//  ARB_RR_LOCK_EN undefined:
//   - No lock port.
//   - Tenure is always bounded by MAX_HOLD.
// TESTING  (N=3, MAX_HOLD=4 unless noted)
//  1 Reset: rst=0 with req=3'b111 -> gnt=0, gnt_valid=0, gnt_id=0 throughout. Release rst -> first edge gnt=3'b001.
//  2 Single holder: req=3'b001 for 10 cycles -> gnt=3'b001 continuously, no idle cycle. Drop req -> gnt=0 next edge.
//  3 Fairness: req=3'b111 held -> gnt sequence 001 x4, 010 x4, 100 x4, 001 ...; gnt_id 0,1,2,0.
//  4 Early release: owner 0 drops req at its 2nd cycle while req[2]=1 -> next edge gnt=3'b100, gnt_id=2, no bubble.
//  5 Async reset mid-tenure: pulse rst=0 between edges while gnt=3'b010 -> gnt=0 immediately.
//    After release with req=3'b111 -> gnt=3'b001.
//  6 ARB_RR_LOCK_EN: req=3'b011, lock=1 while owner 0 -> gnt=3'b001 for 10 cycles.
//    Drop lock -> gnt=3'b010 next edge. With MAX_HOLD=0 and the macro undefined, owner 0 holds until req[0]=0.

Source files
------------

// File: rtl/arbiter_rr_n_if.sv
// Request/grant bundle shared between the requesters and the round-robin arbiter.
// The lock wire exists only when ARB_RR_LOCK_EN is defined.
interface arbiter_rr_n_if #(
    parameter int N = 3
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
`ifdef ARB_RR_LOCK_EN
    logic           lock;
`endif
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    // Requester side: drives requests, observes the grant.
    modport master (
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        output req
`ifdef ARB_RR_LOCK_EN
        , output lock
`endif
    );

    // Arbiter side: samples requests, drives the registered grant.
    modport slave (
        output gnt,
        output gnt_valid,
        output gnt_id,
        input  req
`ifdef ARB_RR_LOCK_EN
        , input  lock
`endif
    );
endinterface

// File: rtl/arbiter_rr_n.sv
// N-way round-robin arbiter with a bounded grant tenure.
// The owner keeps the grant while it requests, for at most MAX_HOLD cycles
// (MAX_HOLD = 0 means unlimited); then the scan moves on starting after the
// most recent owner. Grant, valid and owner index are all registered.
// Optional feature: define ARB_RR_LOCK_EN to add a lock input that lets the
// current owner keep the grant beyond MAX_HOLD.
module arbiter_rr_n #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    arbiter_rr_n_if.slave  bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LIM = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW:0]   N_EXT    = (IDW + 1)'(N);
    localparam logic [N-1:0]   ONE      = {{(N - 1){1'b0}}, 1'b1};

    logic [N-1:0]   gnt_q;
    logic           gnt_valid_q;
    logic [IDW-1:0] gnt_id_q;
    logic [HCW-1:0] hold_cnt;
    logic [IDW-1:0] last_owner;

    logic           lock_in;
    logic           owner_req;
    logic           under_limit;
    logic           keep;
    logic           found;
    logic [IDW-1:0] scan_id;
    logic [IDW:0]   scan_sum;

`ifdef ARB_RR_LOCK_EN
    assign lock_in = bus.lock;
`else
    assign lock_in = 1'b0;
`endif

    // Decide between keeping the current owner and scanning for the next one;
    // the scan index is one bit wider so last_owner + N cannot overflow.
    always_comb begin
        owner_req   = gnt_valid_q && bus.req[gnt_id_q];
        under_limit = (MAX_HOLD == 0) || (hold_cnt < HOLD_LIM);
        keep        = owner_req && (under_limit || lock_in);
        found       = 1'b0;
        scan_id     = '0;
        scan_sum    = '0;
        for (int k = 1; k <= N; k++) begin
            scan_sum = {1'b0, last_owner} + (IDW + 1)'(k);
            if (scan_sum >= N_EXT) begin
                scan_sum = scan_sum - N_EXT;
            end
            if (!found && bus.req[scan_sum[IDW-1:0]]) begin
                found   = 1'b1;
                scan_id = scan_sum[IDW-1:0];
            end
        end
    end

    // Grant state: keep and extend the tenure, hand over to the scanned
    // requester, or go idle while remembering who owned the resource last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hold_cnt    <= '0;
            last_owner  <= IDW'(N - 1);
        end else if (keep) begin
            if (hold_cnt < HOLD_LIM) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else if (found) begin
            gnt_q       <= ONE << scan_id;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= scan_id;
            last_owner  <= scan_id;
            hold_cnt    <= '0;
        end else begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hold_cnt    <= '0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
endmodule
